// File: rtl/instr_fetch.sv
// instr_fetch: owns the PC, issues imem word reads under a credit limit and buffers responses for decode.
// Build option FETCH_ALIGN_CHECK_EN: a misaligned redirect raises a sticky fetch_fault and halts fetch.
module instr_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pc8,
    input  logic        instr_ready,
    output logic        fetch_fault
);

    // state | meaning
    // IDLE  | first cycle after reset release, no requests yet
    // RUN   | fetching, request gated by outstanding + buffered credit
    // HALT  | misaligned redirect seen, fetch stopped until reset
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;
    localparam int CW1 = CW + 1;
    localparam logic [CW:0] DEPTH_C = CW1'(FIFO_DEPTH);

    logic [1:0]    state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]   fifo_instr_q [FIFO_DEPTH];
    logic [31:0]   fifo_pc_q    [FIFO_DEPTH];

    logic [CW:0]   credit_used;
    logic [31:0]   target_aligned;
    logic          grant;
    logic          push;
    logic          pop;
    logic          align_err;

    assign target_aligned = br_target & 32'hFFFF_FFFC;
    assign credit_used    = {1'b0, inflight_q} + {1'b0, count_q};

    assign imem_req  = (state_q == S_RUN) && (credit_used < DEPTH_C);
    assign imem_addr = pc_q;
    assign grant     = imem_req && imem_gnt;

    // A redirect flushes the buffer, so any push or pop in that cycle is cancelled.
    assign instr_valid = (count_q != '0);
    assign pop         = instr_valid && instr_ready && !br_taken;
    assign push        = imem_rvalid && (drop_q == '0) && !br_taken;

`ifdef FETCH_ALIGN_CHECK_EN
    assign align_err = br_taken && (br_target[1:0] != 2'b00);
`else
    assign align_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = S_RUN;
            S_RUN:   state_d = S_RUN;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
        if (align_err) begin
            state_d = S_HALT;
        end
    end

    always_comb begin
        inflight_d = inflight_q + CW'(grant) - CW'(imem_rvalid);
        pc_d       = grant ? pc_q + 32'd4 : pc_q;
        resp_pc_d  = push ? resp_pc_q + 32'd4 : resp_pc_q;
        drop_d     = (imem_rvalid && (drop_q != '0)) ? drop_q - CW'(1) : drop_q;
        count_d    = count_q + CW'(push) - CW'(pop);
        wr_ptr_d   = wr_ptr_q + AW'(push);
        rd_ptr_d   = rd_ptr_q + AW'(pop);
        // Everything still outstanding after this cycle, including a same-cycle grant, is stale.
        if (br_taken) begin
            pc_d      = target_aligned;
            resp_pc_d = target_aligned;
            drop_d    = inflight_d;
            count_d   = '0;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            resp_pc_q  <= resp_pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_instr_q[i] <= '0;
                fifo_pc_q[i]    <= '0;
            end
        end else if (push) begin
            fifo_instr_q[wr_ptr_q] <= imem_rdata;
            fifo_pc_q[wr_ptr_q]    <= resp_pc_q;
        end
    end

    assign instr     = fifo_instr_q[rd_ptr_q];
    assign instr_pc  = fifo_pc_q[rd_ptr_q];
    assign instr_pc8 = instr_pc + 32'd8;

`ifdef FETCH_ALIGN_CHECK_EN
    logic fault_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_q <= 1'b0;
        end else if (align_err) begin
            fault_q <= 1'b1;
        end
    end

    assign fetch_fault = fault_q;
`else
    assign fetch_fault = 1'b0;
`endif

endmodule
